// File: rtl/fir_pkg.sv
// ---------------------------------------------------------------------------
// fir_pkg
//   Constants, types and helper functions shared by the 8-tap FIR controller
//   (fir_ctrl) and its multiply-accumulate datapath (fir_mac).
//
//   TAPS        number of filter taps (depth of the sample shift line)
//   ADDR_W      width of the sample-RAM and coefficient addresses
//   fir_state_e controller FSM states
//   acc_width() accumulator width derived from the sample/coefficient width
// ---------------------------------------------------------------------------
package fir_pkg;

   localparam int TAPS   = 8;
   localparam int ADDR_W = 3;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_WRITE = 3'd1,
      S_READ  = 3'd2,
      S_LAST  = 3'd3,
      S_OUT   = 3'd4
   } fir_state_e;

   // Eight full-scale products need log2(8) = 3 guard bits on top of the
   // 2*DATA_WIDTH product width, so the sum can never wrap.
   function automatic int acc_width(input int data_w);
      return 2 * data_w + 3;
   endfunction

endpackage

// File: rtl/fir_mac.sv
// ---------------------------------------------------------------------------
// fir_mac
//   Signed multiply-accumulate for the FIR controller. Each enabled cycle adds
//   signed(a) * signed(b), sign-extended to ACC_WIDTH, into the accumulator.
//   clear has priority over enable and zeroes the accumulator.
//
//   Ports
//     clk      rising-edge clock
//     rst_n    asynchronous active-low reset (accumulator -> 0)
//     clear    zero the accumulator on the next edge
//     enable   add a*b on the next edge
//     a, b     signed DATA_WIDTH operands (sample, coefficient)
//     acc      accumulator value, ACC_WIDTH bits two's complement
// ---------------------------------------------------------------------------
module fir_mac
   import fir_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int ACC_WIDTH  = acc_width(DATA_WIDTH)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clear,
   input  logic                  enable,
   input  logic [DATA_WIDTH-1:0] a,
   input  logic [DATA_WIDTH-1:0] b,
   output logic [ACC_WIDTH-1:0]  acc
);

   localparam int PROD_W = 2 * DATA_WIDTH;

   // Sign-extend an operand to the full product width so the multiply is
   // carried out at PROD_W bits without relying on context sizing.
   function automatic logic signed [PROD_W-1:0] sext_operand(
      input logic [DATA_WIDTH-1:0] v
   );
      return signed'({{DATA_WIDTH{v[DATA_WIDTH-1]}}, v});
   endfunction

   // Sign-extend a product to the accumulator width.
   function automatic logic signed [ACC_WIDTH-1:0] sext_product(
      input logic signed [PROD_W-1:0] p
   );
      return signed'({{(ACC_WIDTH-PROD_W){p[PROD_W-1]}}, p});
   endfunction

   logic signed [PROD_W-1:0]    a_ext;
   logic signed [PROD_W-1:0]    b_ext;
   logic signed [PROD_W-1:0]    prod;
   logic signed [ACC_WIDTH-1:0] prod_ext;
   logic signed [ACC_WIDTH-1:0] acc_d;
   logic signed [ACC_WIDTH-1:0] acc_q;

   assign a_ext    = sext_operand(a);
   assign b_ext    = sext_operand(b);
   assign prod     = a_ext * b_ext;
   assign prod_ext = sext_product(prod);

   always_comb begin
      acc_d = acc_q;
      if (clear) begin
         acc_d = '0;
      end else if (enable) begin
         acc_d = acc_q + prod_ext;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q <= '0;
      end else begin
         acc_q <= acc_d;
      end
   end

   assign acc = acc_q;

endmodule

// File: rtl/fir_ctrl.sv
// ---------------------------------------------------------------------------
// fir_ctrl
//   Sequencer for an 8-tap FIR filter built around an external sample RAM
//   (an 8-deep shift line) and an external registered coefficient ROM.
//   One sample in -> one filtered result out:
//     IDLE  : accept a sample
//     WRITE : push the sample into the shift line, clear the accumulator
//     READ  : sweep taps 0..7 on ram_addr / coef_addr
//     LAST  : fold in the final product
//     OUT   : present the result until out_ready
//   Result appears 11 cycles after the input handshake.
//
//   Ports
//     clk, rst_n            clock, asynchronous active-low reset
//     in_valid/in_ready     sample handshake, in_data signed sample
//     ram_en, ram_we        sample-RAM enable / write strobe
//     ram_addr, ram_di      sample-RAM read address / write data
//     ram_dio               sample-RAM registered read data
//     coef_addr, coef_data  coefficient address / data (one cycle later)
//     out_valid/out_ready   result handshake, out_data signed result
// ---------------------------------------------------------------------------
module fir_ctrl
   import fir_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int ACC_WIDTH  = acc_width(DATA_WIDTH)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  ram_en,
   output logic                  ram_we,
   output logic [ADDR_W-1:0]     ram_addr,
   output logic [DATA_WIDTH-1:0] ram_di,
   input  logic [DATA_WIDTH-1:0] ram_dio,
   output logic [ADDR_W-1:0]     coef_addr,
   input  logic [DATA_WIDTH-1:0] coef_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [ACC_WIDTH-1:0]  out_data
);

   localparam logic [ADDR_W-1:0] LAST_TAP = ADDR_W'(TAPS - 1);

   fir_state_e             state_d,  state_q;
   logic [ADDR_W-1:0]      index_d,  index_q;
   logic [DATA_WIDTH-1:0]  sample_d, sample_q;
   logic                   mac_clear;
   logic                   mac_en;
   logic [ACC_WIDTH-1:0]   acc;

   // in_ready is gated by rst_n so it reads 0 while reset is held, yet is
   // already 1 at the first edge after release (state is IDLE out of reset).
   assign in_ready = rst_n && (state_q == S_IDLE);

   always_comb begin
      state_d   = state_q;
      index_d   = index_q;
      sample_d  = sample_q;
      mac_clear = 1'b0;
      mac_en    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (in_valid && in_ready) begin
               sample_d = in_data;
               state_d  = S_WRITE;
            end
         end
         S_WRITE: begin
            index_d   = '0;
            mac_clear = 1'b1;
            state_d   = S_READ;
         end
         S_READ: begin
            index_d = index_q + ADDR_W'(1);
            // RAM and ROM data lag the address by one cycle, so the product
            // for tap k is available while tap k+1 is being addressed.
            mac_en  = (index_q != '0);
            if (index_q == LAST_TAP) begin
               state_d = S_LAST;
            end
         end
         S_LAST: begin
            mac_en  = 1'b1;
            state_d = S_OUT;
         end
         S_OUT: begin
            if (out_ready) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         index_q  <= '0;
         sample_q <= '0;
      end else begin
         state_q  <= state_d;
         index_q  <= index_d;
         sample_q <= sample_d;
      end
   end

   fir_mac #(
      .DATA_WIDTH (DATA_WIDTH),
      .ACC_WIDTH  (ACC_WIDTH)
   ) u_mac (
      .clk    (clk),
      .rst_n  (rst_n),
      .clear  (mac_clear),
      .enable (mac_en),
      .a      (ram_dio),
      .b      (coef_data),
      .acc    (acc)
   );

   // The RAM is touched only in WRITE and READ; every other state (and reset)
   // leaves it idle, so an abort never produces a stray write.
   assign ram_en    = (state_q == S_WRITE) || (state_q == S_READ);
   assign ram_we    = (state_q == S_WRITE);
   assign ram_addr  = index_q;
   assign coef_addr = index_q;
   assign ram_di    = sample_q;
   assign out_valid = (state_q == S_OUT);
   assign out_data  = acc;

endmodule

// File: tb/tb_fir_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fir_ctrl
//   Bench for fir_ctrl. Provides a behavioural sample RAM (8-deep shift line,
//   registered read) and a registered coefficient ROM, drives directed and
//   random transactions, and compares each result against the dot product of
//   the coefficient table with the most recent eight accepted samples.
// ---------------------------------------------------------------------------
module tb_fir_ctrl;

   localparam int DW    = 8;
   localparam int ACC_W = 2 * DW + 3;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic [DW-1:0]    in_data;
   logic             ram_en;
   logic             ram_we;
   logic [2:0]       ram_addr;
   logic [DW-1:0]    ram_di;
   logic [DW-1:0]    ram_dio = '0;
   logic [2:0]       coef_addr;
   logic [DW-1:0]    coef_data = '0;
   logic             out_valid;
   logic             out_ready;
   logic [ACC_W-1:0] out_data;

   int tests = 0;
   int fails = 0;

   int coef [8];
   int hist [$];
   logic [DW-1:0] mem [8] = '{default: '0};

   always #5 clk = ~clk;

   fir_ctrl #(.DATA_WIDTH(DW), .ACC_WIDTH(ACC_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .ram_en    (ram_en),
      .ram_we    (ram_we),
      .ram_addr  (ram_addr),
      .ram_di    (ram_di),
      .ram_dio   (ram_dio),
      .coef_addr (coef_addr),
      .coef_data (coef_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data)
   );

   // Sample RAM (shift line, not reset) and coefficient ROM.
   always @(posedge clk) begin
      if (ram_en && ram_we) begin
         for (int i = 7; i > 0; i--) mem[i] <= mem[i-1];
         mem[0] <= ram_di;
      end else if (ram_en) begin
         ram_dio <= mem[ram_addr];
      end
      coef_data <= DW'(coef[coef_addr]);
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
      tests++;
      assert (obs === exp_v) else begin
         fails++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
      end
   endtask

   // y = sum over taps of c[i] * x[n-i]; never-written taps hold 0.
   function automatic int model();
      int s = 0;
      for (int i = 0; i < hist.size(); i++) s += coef[i] * hist[i];
      return s;
   endfunction

   function automatic void push_sample(input logic [DW-1:0] x);
      hist.push_front(int'(signed'(x)));
      if (hist.size() > 8) void'(hist.pop_back());
   endfunction

   // One transaction: handshake, busy-phase timing, result, exit.
   //   hold  : cycles out_ready stays low once OUT is reached
   //   early : out_ready already high before OUT is entered
   //   bp    : keep in_valid high while held in OUT
   task automatic run_txn(input logic [DW-1:0] x, input int hold, input bit early,
                          input bit bp, output logic [ACC_W-1:0] got);
      int k;
      int lat;
      int bad;
      logic [ACC_W-1:0] exp_v;
      k = 0;
      while (in_ready !== 1'b1 && k < 50) begin
         @(negedge clk);
         k++;
      end
      check("in_ready_wait", 64'(in_ready), 64'(1));
      push_sample(x);
      exp_v     = ACC_W'(model());
      in_valid  = 1'b1;
      in_data   = x;
      out_ready = early;
      @(negedge clk);
      in_valid = 1'b0;
      lat = 1;
      bad = 0;
      while (out_valid !== 1'b1 && lat < 40) begin
         if (ram_we !== (lat == 1)) bad++;
         if (ram_en !== (lat <= 9)) bad++;
         if (lat >= 2 && lat <= 9 &&
             (ram_addr !== 3'(lat - 2) || coef_addr !== 3'(lat - 2))) bad++;
         if (in_ready !== 1'b0) bad++;
         in_valid = 1'($urandom_range(0, 1));
         in_data  = DW'($urandom);
         @(negedge clk);
         lat++;
      end
      check("busy_timing", 64'(bad), 64'(0));
      check("latency", 64'(lat), 64'(11));
      check("out_data", 64'(out_data), 64'(exp_v));
      got = out_data;
      if (early) begin
         in_valid = 1'b0;
         @(negedge clk);
         check("early_exit", 64'({out_valid, in_ready}), 64'(2'b01));
         out_ready = 1'b0;
      end else begin
         in_valid = bp;
         bad = 0;
         for (int h = 0; h < hold; h++) begin
            if (out_data !== got || out_valid !== 1'b1 || in_ready !== 1'b0 ||
                ram_we !== 1'b0 || ram_en !== 1'b0) bad++;
            in_data = DW'($urandom);
            @(negedge clk);
         end
         check("hold_stable", 64'(bad), 64'(0));
         in_valid  = 1'b0;
         out_ready = 1'b1;
         @(negedge clk);
         out_ready = 1'b0;
         check("release", 64'(out_valid), 64'(0));
      end
   endtask

   initial begin
      logic [ACC_W-1:0] got;
      logic [DW-1:0]    x;
      int imp_in  [9] = '{1, 0, 0, 0, 0, 0, 0, 0, 0};
      int imp_exp [9] = '{1, 2, 3, 4, 5, 6, 7, 8, 0};

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;
      for (int i = 0; i < 8; i++) coef[i] = i + 1;

      // Reset state.
      #3;
      check("rst_in_ready",  64'(in_ready),  64'(0));
      check("rst_out_valid", 64'(out_valid), 64'(0));
      check("rst_out_data",  64'(out_data),  64'(0));
      check("rst_ram_en_we", 64'({ram_en, ram_we}), 64'(0));
      check("rst_addrs",     64'({ram_addr, coef_addr}), 64'(0));
      check("rst_ram_di",    64'(ram_di), 64'(0));
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("in_ready_after_reset", 64'(in_ready), 64'(1));
      @(negedge clk);

      // Impulse response.
      for (int k = 0; k < 9; k++) begin
         run_txn(DW'(imp_in[k]), k % 3, 1'b0, 1'b0, got);
         check($sformatf("impulse_%0d", k), 64'(got), 64'(ACC_W'(imp_exp[k])));
      end

      // Full-scale positive.
      for (int i = 0; i < 8; i++) coef[i] = 127;
      for (int k = 0; k < 9; k++) begin
         run_txn(8'd127, 0, 1'b0, 1'b0, got);
         if (k >= 7) check($sformatf("maxpos_%0d", k), 64'(got), 64'(ACC_W'(129032)));
      end

      // Full-scale negative.
      for (int i = 0; i < 8; i++) coef[i] = -128;
      for (int k = 0; k < 8; k++) begin
         run_txn(8'h80, 1, 1'b0, 1'b0, got);
         if (k == 7) check("maxneg_8", 64'(got), 64'(ACC_W'(131072)));
      end

      // Backpressure with in_valid held high in OUT.
      run_txn(DW'($urandom), 20, 1'b0, 1'b1, got);

      // out_ready already high when OUT is entered.
      run_txn(DW'($urandom), 0, 1'b1, 1'b0, got);

      // Reset during READ.
      x = DW'($urandom);
      while (in_ready !== 1'b1) @(negedge clk);
      push_sample(x);
      in_valid = 1'b1;
      in_data  = x;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (4) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midrst_outputs",
            64'({in_ready, out_valid, ram_en, ram_we, ram_addr, coef_addr, ram_di, out_data}),
            64'(0));
      @(negedge clk);
      check("midrst_held", 64'({ram_en, ram_we, out_valid}), 64'(0));
      rst_n = 1'b1;
      #1;
      check("midrst_in_ready", 64'(in_ready), 64'(1));
      @(negedge clk);
      run_txn(DW'($urandom), 0, 1'b0, 1'b0, got);

      // Random coefficients and samples.
      for (int t = 0; t < 20; t++) begin
         if (t % 5 == 0) begin
            for (int i = 0; i < 8; i++) coef[i] = int'($urandom_range(0, 255)) - 128;
         end
         run_txn(DW'($urandom), int'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), 1'b0, got);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/fir_ctrl.md
FIR_CTRL -- requirements
Module: fir_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 8, SHALL set the sample and coefficient width in bits.
REQ-002 Parameter ACC_WIDTH, default 2*DATA_WIDTH+3, SHALL set the accumulator and result width in bits.
REQ-003 clock  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset  in  1  SHALL be the asynchronous, active-low reset.
REQ-005 in_valid  in  1  SHALL flag that a new sample is offered.
REQ-006 in_ready  out  1  SHALL flag that a sample is accepted this cycle.
REQ-007 in_data  in  DATA_WIDTH  SHALL carry the signed sample.
REQ-008 ram_en, ram_we  out  1 each  SHALL be the sample-RAM enable and write strobe.
REQ-009 ram_addr  out  3  SHALL be the sample-RAM read address.
REQ-010 ram_di  out  DATA_WIDTH  SHALL be the sample-RAM write data.
REQ-011 ram_dio  in  DATA_WIDTH  SHALL be the registered sample-RAM read data.
REQ-012 coef_addr  out  3  SHALL be the coefficient address.
REQ-013 coef_data  in  DATA_WIDTH  SHALL be the signed coefficient, valid one cycle after coef_addr.
REQ-014 out_valid  out  1, out_ready  in  1, out_data  out  ACC_WIDTH  SHALL form the result handshake.

Function
REQ-015 The sample RAM SHALL be treated as an 8-deep shift line: a write shifts all entries up by one, stores ram_di at entry 0, and read data appears on ram_dio one cycle after ram_en with ram_we low.
REQ-016 The FSM SHALL have states IDLE, WRITE, READ, LAST and OUT.
REQ-017 IDLE: in_ready=1; on in_valid&in_ready, register in_data and go to WRITE; otherwise stay in IDLE.
REQ-018 WRITE: ram_en=1, ram_we=1, ram_di=registered sample; clear accumulator and tap index; go to READ.
REQ-019 READ: ram_en=1, ram_we=0, ram_addr=coef_addr=index; index increments each cycle 0..7; after index 7 go to LAST.
REQ-020 From the second READ cycle through LAST, the accumulator SHALL add signed(ram_dio)*signed(coef_data) for the previous index.
REQ-021 Arithmetic SHALL be two's-complement, sign-extended to ACC_WIDTH; no saturation is needed because 8 products of DATA_WIDTH bits cannot overflow ACC_WIDTH.
REQ-022 LAST: add the index-7 product; go to OUT.
REQ-023 OUT: out_valid=1, out_data=accumulator held stable; on out_ready go to IDLE; otherwise stay in OUT.
REQ-024 Latency SHALL be: input handshake in cycle T, out_valid first high in cycle T+11.
REQ-025 in_ready SHALL be 0 in every state except IDLE; in_valid outside IDLE SHALL be ignored with no RAM access.
REQ-026 Sustained out_ready=0 SHALL hold OUT and out_data indefinitely, with no new input accepted.
REQ-027 out_ready already high when OUT is entered SHALL leave OUT after exactly one cycle; the next input SHALL be accepted one cycle later in IDLE.
REQ-028 ram_en and ram_we SHALL be 0 in IDLE, LAST and OUT.

Reset
REQ-029 While reset=0: state=IDLE, in_ready=0, out_valid=0, out_data=0, ram_en=0, ram_we=0, ram_addr=0, ram_di=0, coef_addr=0, accumulator=0, index=0.
REQ-030 Reset asserted mid-operation SHALL abort immediately with no further RAM write; the sample RAM contents are not cleared by this block.
REQ-031 The first rising clock edge after reset deasserts SHALL see in_ready=1.

Structure
REQ-032 A shared package fir_pkg SHALL hold TAPS=8, ADDR_W=3, the FSM state enum and the ACC_WIDTH derivation.
REQ-033 The multiply-accumulate SHALL be one sub-module, fir_mac, with inputs clear, enable, a and b, and output acc.

Verification
REQ-034 Impulse test: coef c[i]=i+1; samples 1,0,0,0,0,0,0,0,0 -> outputs 1,2,3,4,5,6,7,8,0.
REQ-035 Max positive test: all coefs 127; nine samples of 127 -> eighth and ninth outputs 129032.
REQ-036 Max negative test: all coefs -128; eight samples of -128 -> eighth output 131072, no overflow.
REQ-037 Backpressure test: out_ready low for 20 cycles with in_valid high -> out_data stable, in_ready=0, no ram_we pulse.
REQ-038 Reset mid-READ test: reset low at T+5 -> all outputs 0 asynchronously; after release, in_ready=1 and the next result is correct.
REQ-039 Timing test: input accepted at cycle T -> ram_we only at T+1, ram_addr sweeps 0..7 over T+2..T+9, out_valid rises at T+11.
